// File: rtl/l3_glb_read_arb_pkg.sv
// Shared token_engine definitions for the GLB read arbiter: parameter defaults and the
// read-return tag carried alongside each outstanding GLB read.
package l3_glb_read_arb_pkg;

  localparam int NUM_REQ_DEF = 32;
  localparam int RD_LAT_DEF  = 2;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W      = 32;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Round-robin successor of a lane, wrapping at the last lane.
  function automatic logic [ID_W-1:0] next_lane(input logic [ID_W-1:0] lane, input int num_req);
    return (int'(lane) == num_req - 1) ? '0 : lane + ID_W'(1);
  endfunction

endpackage

// File: rtl/l3_glb_read_arb_if.sv
// Lane request/flush/grant, GLB read port and FIFO push bundle of the GLB read arbiter.
// master = arbiter side, slave = lanes + GLB side.
interface l3_glb_read_arb_if
  import l3_glb_read_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]             rd_req_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr_i;
  logic [NUM_REQ-1:0]             flush_i;
  logic [NUM_REQ-1:0]             grant_o;
  logic                           glb_rd_ready_i;
  logic                           glb_rd_en_o;
  logic [ADDR_W-1:0]              glb_rd_addr_o;
  logic [DATA_W-1:0]              glb_rd_data_i;
  logic [NUM_REQ-1:0]             push_en_o;
  logic [DATA_W-1:0]              push_data_o;
  logic                           busy_o;

  modport master (
    input  rd_req_i, rd_addr_i, flush_i, glb_rd_ready_i, glb_rd_data_i,
    output grant_o, glb_rd_en_o, glb_rd_addr_o, push_en_o, push_data_o, busy_o
  );

  modport slave (
    output rd_req_i, rd_addr_i, flush_i, glb_rd_ready_i, glb_rd_data_i,
    input  grant_o, glb_rd_en_o, glb_rd_addr_o, push_en_o, push_data_o, busy_o
  );

endinterface

// File: rtl/l3_glb_read_arb_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting lane at or above ptr, else lowest overall.
// Zero latency; an empty request vector gives an all-zero grant.
module l3_glb_read_arb_rr_arbiter #(
  parameter int NUM_REQ = 32,
  parameter int PTR_W   = 5
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] ptr_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;

  assign ptr_mask = {NUM_REQ{1'b1}} << ptr;
  assign req_hi   = req & ptr_mask;
  // Nothing at/above the pointer means the search wraps to lane 0.
  assign pick     = (|req_hi) ? req_hi : req;
  assign grant    = pick & ((~pick) + NUM_REQ'(1));

endmodule

// File: rtl/l3_glb_read_arb.sv
// Round-robin GLB read arbiter: combinational grant, registered read strobe/address next cycle,
// FIFO push RD_LAT cycles later; no grant while the GLB port is not ready, returns never stall.
module l3_glb_read_arb
  import l3_glb_read_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  l3_glb_read_arb_if.master bus
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_grant;
  logic               grant_any;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] push_en;
  logic [DATA_W-1:0]  push_data;
  logic               busy;

  tag_t tag_q    [RD_LAT+1];
  tag_t tag_live [RD_LAT+1];

  assign eligible = bus.glb_rd_ready_i ? (bus.rd_req_i & ~bus.flush_i) : '0;

  l3_glb_read_arb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  assign grant_any   = |arb_grant;
  assign bus.grant_o = rst ? '0 : arb_grant;

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) winner = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= next_lane(winner, NUM_REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.glb_rd_en_o   <= 1'b0;
      bus.glb_rd_addr_o <= '0;
    end else begin
      bus.glb_rd_en_o <= grant_any;
      if (grant_any) bus.glb_rd_addr_o <= bus.rd_addr_i[winner];
    end
  end

  // A flushed lane loses its outstanding tags in the very cycle the flush is seen.
  always_comb begin
    for (int i = 0; i <= RD_LAT; i++) begin
      tag_live[i]       = tag_q[i];
      tag_live[i].valid = tag_q[i].valid & ~bus.flush_i[tag_q[i].id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_any, id: winner};
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_live[i-1];
    end
  end

  always_comb begin
    push_en = '0;
    if (tag_live[RD_LAT].valid) push_en[tag_live[RD_LAT].id] = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) busy = busy | tag_live[i].valid;
  end

  assign push_data       = bus.glb_rd_data_i;
  assign bus.push_en_o   = push_en;
  assign bus.push_data_o = push_data;
  assign bus.busy_o      = busy;

endmodule
